// File: rtl/occ_rom_arbiter_if.sv
// Lane-side request/response bundle of the Occ ROM arbiter.
interface occ_rom_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ*ADDR_W-1:0] req_addr1_i;
    logic [NREQ*ADDR_W-1:0] req_addr2_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]      rsp_data1_o;
    logic [DATA_W-1:0]      rsp_data2_o;
    logic                   busy_o;

    modport slave (
        input  req_valid_i, req_addr1_i, req_addr2_i,
        output req_ready_o, rsp_valid_o, rsp_data1_o, rsp_data2_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr1_i, req_addr2_i,
        input  req_ready_o, rsp_valid_o, rsp_data1_o, rsp_data2_o, busy_o
    );
endinterface

// File: rtl/occ_rom_arbiter.sv
// Round-robin sharing of the dual-address Occ ROM between NREQ search lanes.
// Optional OCC_ARB_LANE0_PRIO_EN: lane 0 (backtrack/refill) always wins when valid.
module occ_rom_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    occ_rom_arbiter_if.slave  lane,
    output logic              ce_rom_Occ_o,
    output logic [ADDR_W-1:0] addr1_rom_Occ_o,
    output logic [ADDR_W-1:0] addr2_rom_Occ_o,
    input  logic [DATA_W-1:0] data_1_i,
    input  logic [DATA_W-1:0] data_2_i
);
    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ROM_LAT-1:0] tag_vld_q;
    logic [PTR_W-1:0]   tag_idx_q [ROM_LAT];

    logic               hi_found, lo_found;
    logic [PTR_W-1:0]   hi_idx, lo_idx, win;
    logic               grant_vld;
    logic [NREQ-1:0]    ready;
    logic [ADDR_W-1:0]  addr1, addr2;
    logic [NREQ-1:0]    rsp_valid;

    // Winner: first valid lane at or above ptr, else first valid lane from 0 (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            if (lane.req_valid_i[n]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(n);
                end
                if (!hi_found && (PTR_W'(n) >= ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(n);
                end
            end
        end
        grant_vld = lo_found;
        win       = hi_found ? hi_idx : lo_idx;
`ifdef OCC_ARB_LANE0_PRIO_EN
        if (lane.req_valid_i[0]) win = '0;
`endif
    end

    always_comb begin
        ready = '0;
        addr1 = '0;
        addr2 = '0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            if (grant_vld && (win == PTR_W'(n))) begin
                ready[n] = 1'b1;
                addr1    = lane.req_addr1_i[n*ADDR_W +: ADDR_W];
                addr2    = lane.req_addr2_i[n*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef OCC_ARB_LANE0_PRIO_EN
        if (grant_vld && !lane.req_valid_i[0]) ptr_d = (win == LAST) ? '0 : win + PTR_W'(1);
`else
        if (grant_vld) ptr_d = (win == LAST) ? '0 : win + PTR_W'(1);
`endif
    end

    // Pointer and tag pipe; stage ROM_LAT-1 lines up with the ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) tag_idx_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= grant_vld;
            tag_idx_q[0] <= win;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned n = 0; n < NREQ; n++)
            rsp_valid[n] = tag_vld_q[ROM_LAT-1] && (tag_idx_q[ROM_LAT-1] == PTR_W'(n));
    end

    assign lane.req_ready_o = ready;
    assign lane.rsp_valid_o = rsp_valid;
    assign lane.rsp_data1_o = data_1_i;
    assign lane.rsp_data2_o = data_2_i;
    assign lane.busy_o      = |tag_vld_q;
    assign ce_rom_Occ_o     = grant_vld;
    assign addr1_rom_Occ_o  = addr1;
    assign addr2_rom_Occ_o  = addr2;
endmodule
